// File: rtl/bcd_pkg.sv
// Shared types and width helpers for the BCD <-> binary converter pair.
package bcd_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // MSB index of the packed BCD word that holds any W-bit binary value.
  function automatic int unsigned bcd_msb(input int unsigned w);
    return w + (w - 4) / 3;
  endfunction

  // Nibble count after zero-extending the BCD word to a multiple of 4 bits.
  function automatic int unsigned nibbles(input int unsigned w);
    return (bcd_msb(w) + 4) / 4;
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// One reverse-double-dabble digit correction: a nibble of 8 or more
// came from a shifted-in tens bit and is brought back into 0..9 by subtracting 3.
module bcd_nibble_adj (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // Subtract 3 (4-bit wrap) when the nibble is 8 or above.
  assign adj = (nib >= 4'd8) ? (nib - 4'd3) : nib;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative packed-BCD to binary converter, one shift/adjust step per clock.
// Inverse of the combinational binary-to-BCD converter; valid/ready on both sides.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned W     = 19,
  parameter int unsigned BCD_W = bcd_msb(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BCD_W:0] in_bcd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_bin,
  output logic           out_err,
  output logic           out_ovf
);

  localparam int unsigned ND = (BCD_W + 4) / 4;
  localparam int unsigned BW = 4 * ND;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  conv_state_e   state;
  logic [BW-1:0] bcd_r;
  logic [W-1:0]  bin_r;
  logic          err_r;
  logic [CW-1:0] cnt;

  logic [BW-1:0]   in_ext;
  logic            err_in;
  logic [BW+W-1:0] shifted;
  logic [BW-1:0]   bcd_sh;
  logic [BW-1:0]   bcd_nxt;
  logic [W-1:0]    bin_nxt;

  // Accept a new word only while idle; decoded from state alone.
  assign in_ready = (state == IDLE);

  // Zero-extend the input so every nibble is 4 bits wide.
  assign in_ext = BW'(in_bcd);

  // Flag any full input nibble above 9; the partial top nibble is exempt.
  always_comb begin
    err_in = 1'b0;
    for (int k = 0; k < int'(ND) - 1; k++) begin
      if (in_ext[4*k +: 4] > 4'd9) begin
        err_in = 1'b1;
      end
    end
  end

  // Shift the combined work register right by one place.
  assign shifted = {bcd_r, bin_r} >> 1;
  assign bcd_sh  = shifted[BW+W-1:W];
  assign bin_nxt = shifted[W-1:0];

  // Per-digit correction after the shift.
  for (genvar g = 0; g < int'(ND); g++) begin : gen_adj
    bcd_nibble_adj u_adj (
      .nib (bcd_sh[4*g +: 4]),
      .adj (bcd_nxt[4*g +: 4])
    );
  end

  // Sequencer, work registers and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcd_r     <= '0;
      bin_r     <= '0;
      err_r     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bcd_r <= in_ext;
            bin_r <= '0;
            err_r <= err_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_r <= bcd_nxt;
          bin_r <= bin_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            // Anything left in the BCD half means the value did not fit in W bits.
            out_bin   <= bin_nxt;
            out_ovf   <= |bcd_nxt;
            out_err   <= err_r;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq with a decimal-digit loopback model.
module tb_bcd_to_bin_seq;

  localparam int unsigned W  = 19;
  localparam int unsigned BI = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BI-1:0] in_bcd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_bin;
  logic          out_err;
  logic          out_ovf;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err),
    .out_ovf   (out_ovf)
  );

  // Decimal digits of v packed as BCD, independent of the shift/adjust method.
  function automatic logic [BI-1:0] to_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < 7; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r[BI-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Offer a word and return #1 after the handshake edge.
  task automatic send(input logic [BI-1:0] v);
    int n;
    n = 0;
    in_bcd   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bcd   = '0;
  endtask

  // Wait (bounded) for out_valid; lat counts clock edges after the handshake edge.
  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Consume the result and confirm the block is back in IDLE.
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [BI-1:0] v, input logic [W-1:0] eb,
                     input logic ee, input logic eo, input bit chk_bin);
    int lat;
    send(v);
    wait_out(tag, lat);
    check({tag, "_lat"}, 32'(lat), 32'(W));
    if (chk_bin) check({tag, "_bin"}, 32'(out_bin), 32'(eb));
    check({tag, "_err"}, 32'(out_err), 32'(ee));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    release_out(tag);
  endtask

  initial begin
    int lat;
    int unsigned v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bin", 32'(out_bin), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);

    // Basic conversions and range boundary.
    run("zero", 25'h0000000, 19'd0, 1'b0, 1'b0, 1'b1);
    run("max", 25'h0524287, 19'h7FFFF, 1'b0, 1'b0, 1'b1);
    run("d42", 25'h0000042, 19'd42, 1'b0, 1'b0, 1'b1);

    // Overflow: result is the value modulo 2^W.
    run("ovf_lo", 25'h0524288, 19'd0, 1'b0, 1'b1, 1'b1);
    run("ovf_hi", 25'h1999999, 19'd427135, 1'b0, 1'b1, 1'b1);

    // Illegal digit still yields a valid result with the error flag.
    run("bad_nib", 25'h00000A5, 19'd0, 1'b1, 1'b0, 1'b0);
    // Partial top nibble is not digit-checked.
    run("top_bit", 25'h1000000, 19'd475712, 1'b0, 1'b1, 1'b1);

    // Input offered during SHIFT is ignored.
    send(25'h0000042);
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_bcd   = 25'h0000999;
    check("shift_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bcd   = '0;
    wait_out("bp", lat);
    check("bp_bin", 32'(out_bin), 32'd42);

    // Backpressure: result held, no acceptance while DONE.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bcd   = 25'h0000555;
      @(posedge clk); #1;
      check("bp_hold_bin", 32'(out_bin), 32'd42);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_flags", 32'({out_err, out_ovf}), 32'd0);
    end
    in_valid = 1'b0;
    in_bcd   = '0;
    release_out("bp");
    run("after_bp", 25'h0000077, 19'd77, 1'b0, 1'b0, 1'b1);

    // Reset during SHIFT cycle 7 aborts the conversion.
    send(25'h0999999);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_bin", 32'(out_bin), 32'd0);
    run("d123", 25'h0000123, 19'd123, 1'b0, 1'b0, 1'b1);

    // Random loopback through a decimal-digit model.
    for (int i = 0; i < 2000; i++) begin
      v = $urandom_range(0, (1 << W) - 1);
      run("loop", to_bcd(v), W'(v), 1'b0, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
